// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store front end for a word-addressed single-port RAM
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      core request handshake
//   req_write, req_size,     request fields: store flag, size (00 byte, 01 half, 10 word),
//   req_unsigned, req_addr,  zero/sign extension select for loads, byte address,
//   req_wdata                right-aligned store data
//   resp_valid/resp_ready    core response handshake
//   resp_rdata, resp_error   extended load data (0 for stores/errors), error flag
//   mem_addr                 RAM word index (registered, zero-extended)
//   mem_write_enable         RAM write strobe (one cycle, only in WR)
//   mem_write_data           RAM write word
//   mem_read_data            RAM read word, valid the cycle after mem_addr is presented
module load_store_unit #(
    parameter int WORD_ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    logic [2:0]  r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;      // only sub-word stores need the data after accept
    logic [31:0] r_mem_addr;
    logic        r_mem_we;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_resp_rdata;
    logic        r_resp_error;

    logic        w_accept;
    logic        w_range_err;
    logic        w_err;
    logic [31:0] w_word_idx;
    logic [4:0]  w_shift;
    logic [31:0] w_shifted;
    logic [31:0] w_load_val;
    logic [31:0] w_lane_mask;
    logic [31:0] w_insert;
    logic [31:0] w_merged;

    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_error = r_resp_error;
    assign mem_addr   = r_mem_addr;
    assign mem_write_data = r_mem_wdata;
    // Gate the strobe combinationally so a reset asserted during WR can never write.
    assign mem_write_enable = r_mem_we && !rst;

    // Any set bit above the RAM's word-index field puts the access out of range.
    assign w_range_err = |req_addr[31:WORD_ADDR_BITS+2];
    assign w_err = (req_size == SZ_ILL)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                || w_range_err;
    assign w_word_idx = {{(32-WORD_ADDR_BITS){1'b0}}, req_addr[WORD_ADDR_BITS+1:2]};

    // Lane extraction for loads: bring the addressed lane down to bit 0, then extend.
    assign w_shift   = {r_lane, 3'b000};
    assign w_shifted = mem_read_data >> w_shift;

    always_comb begin
        w_load_val = w_shifted;
        case (r_size)
            SZ_BYTE: w_load_val = r_unsigned ? {24'd0, w_shifted[7:0]}
                                             : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: w_load_val = r_unsigned ? {16'd0, w_shifted[15:0]}
                                             : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_val = w_shifted;
        endcase
    end

    // Read-modify-write merge: replace only the addressed lanes of the fetched word.
    assign w_lane_mask = ((r_size == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
    assign w_insert    = ((r_size == SZ_BYTE) ? {24'd0, r_wdata[7:0]} : {16'd0, r_wdata}) << w_shift;
    assign w_merged    = (mem_read_data & ~w_lane_mask) | w_insert;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_size       <= SZ_BYTE;
            r_unsigned   <= 1'b0;
            r_lane       <= 2'b00;
            r_wdata      <= 16'd0;
            r_mem_addr   <= 32'd0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= 32'd0;
            r_resp_rdata <= 32'd0;
            r_resp_error <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_lane     <= req_addr[1:0];
                        r_wdata    <= req_wdata[15:0];
                        if (w_err) begin
                            r_resp_error <= 1'b1;
                            r_resp_rdata <= 32'd0;
                            r_state      <= S_RESP;
                        end else if (req_write && (req_size == SZ_WORD)) begin
                            r_mem_addr  <= w_word_idx;
                            r_mem_wdata <= req_wdata;
                            r_mem_we    <= 1'b1;
                            r_state     <= S_WR;
                        end else begin
                            r_mem_addr <= w_word_idx;
                            r_state    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    // The RAM captures mem_addr at the end of this cycle.
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (r_write) begin
                        r_mem_wdata <= w_merged;
                        r_mem_we    <= 1'b1;
                        r_state     <= S_WR;
                    end else begin
                        r_resp_rdata <= w_load_val;
                        r_resp_error <= 1'b0;
                        r_state      <= S_RESP;
                    end
                end
                S_WR: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_rdata <= 32'd0;
                        r_resp_error <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
